face_result_reporter: RTL and testbench
=======================================

// Module: face_result_reporter
// PURPOSE
//  Output end of the face detection pipeline, on the clk_fpga side. Pixels stream in, and the
//  classifier raises detection hits (window x, y, scale). This block buffers those hits per
//  frame in a FIFO and presents them to the OS-side reader over a valid/ready stream.
//  It closes each frame with an end-of-frame marker word that carries the hit count and an
//  overflow flag.
// PARAMETERS
//  COORD_WIDTH  10  bits per window coordinate (x, y)
//  SCALE_WIDTH  4   bits of scale index
//  FIFO_DEPTH   16  entries; power of 2, >= 4
//  MERGE_DIST   2   max |dx| and |dy| for duplicate merge (MERGE_SUPPRESS_EN only)
// PORTS
//  clk_fpga    in   1                      single clock; all logic on rising edge
//  reset_fpga  in   1                      asynchronous, active-low reset
//  det_valid   in   1                      classifier hit strobe, 1 cycle per hit
//  det_x       in   COORD_WIDTH            hit window x
//  det_y       in   COORD_WIDTH            hit window y
//  det_scale   in   SCALE_WIDTH            hit scale index
//  frame_end   in   1                      1-cycle pulse after last window of frame
//  res_valid   out  1                      head word available
//  res_ready   in   1                      reader accepts head word
//  res_data    out  W=1+SCALE_WIDTH+2*COORD_WIDTH   {eof, scale, y, x}
//  res_count   out  8                      hits accepted in current frame, saturates at 255
//  overflow    out  1                      sticky: a hit was dropped in current frame
//  fifo_level  out  $clog2(FIFO_DEPTH)+1   occupied entries
// BEHAVIOUR
//  - Reset (async, reset_fpga=0): FIFO pointers cleared; all outputs 0 immediately, including
//    res_data. Hits in flight are discarded. Normal operation resumes on the first edge after
//    reset release.
//  - FIFO is first-word-fall-through:
//      res_valid = (fifo_level != 0); res_data = head entry.
//      Pop when res_valid && res_ready.
//      A word written at edge N is visible on res_valid/res_data after edge N (1-cycle latency).
//  - Handshake: while res_valid && !res_ready, res_data holds stable. res_valid never drops
//    without a pop.
//  - Hit write: on det_valid (and no frame_end), write {1'b0, det_scale, det_y, det_x} if
//    fifo_level < FIFO_DEPTH-1; res_count += 1 (saturating).
//      Otherwise drop the hit and set overflow=1.
//      The last slot is always reserved for the marker.
//  - Marker write: on frame_end, if fifo_level < FIFO_DEPTH, write the marker:
//      eof=1, bit[W-2]=overflow, bits[7:0]=res_count, remaining bits 0.
//      On the same edge, clear res_count and overflow, and clear the merge history.
//    If the FIFO is full (unread markers), drop the marker.
//      res_count and overflow still clear; overflow then sets to 1 for the new frame.
//  - det_valid and frame_end in the same cycle: frame_end has priority.
//      The hit is dropped; the marker is written with overflow=1.
//      res_count and overflow then clear as above.
//  - Push and pop in the same cycle: allowed. The accept decision uses fifo_level at cycle
//    start (pre-pop). fifo_level is unchanged when both occur.
//  - Pointer arithmetic: $clog2(FIFO_DEPTH)-bit pointers wrap modulo FIFO_DEPTH.
//    fifo_level is never > FIFO_DEPTH and never < 0.
//  - Marker width requirement: 2*COORD_WIDTH+SCALE_WIDTH >= 9. Elaboration error otherwise.
// CONFIGURATION
//  MERGE_SUPPRESS_EN defined:
//   - Keep the last accepted (x,y) of the current frame.
//   - A hit with |x-lx| <= MERGE_DIST and |y-ly| <= MERGE_DIST is silently discarded:
//       not written, not counted, overflow untouched.
//   - Differences are computed unsigned, with width COORD_WIDTH+1.
//   - History is invalid after reset and after every frame_end. The first hit of a frame is
//     never merged.
//  MERGE_SUPPRESS_EN undefined: every hit goes through the normal write rules; no history
//  registers.
// TESTING (defaults, res_ready=1 unless stated)
//  1. Reset: drive reset_fpga=0 mid-stream with 5 words queued.
//     -> res_valid=0, fifo_level=0, res_count=0, overflow=0 immediately.
//  2. Hits (10,20,s1), (30,40,s2), (50,60,s3), then frame_end.
//     -> 4 words in order; last word eof=1, count=3, overflow=0.
//  3. res_ready=0; 20 hits, then frame_end.
//     -> 15 hits stored; fifo_level=16; marker count=15, overflow=1.
//  4. 2 hits, then det_valid and frame_end in the same cycle.
//     -> marker count=2, overflow=1; res_count=0 next cycle.
//  5. res_ready toggled every cycle over 10 words.
//     -> res_data stable while stalled; all 10 words received, none lost or duplicated.
//  6. Hits (100,100), (101,102), (104,100), then frame_end.
//     -> with MERGE_SUPPRESS_EN: 2 hits, marker count=2; without: 3 hits, count=3.

Source files
------------

// File: rtl/face_result_reporter.sv
// face_result_reporter
//   Collects classifier hits for each frame in a first-word-fall-through FIFO and
//   streams them to the reader over valid/ready. Each frame is closed with an
//   end-of-frame marker word {eof=1, overflow, ..., count[7:0]}.
//   The last FIFO slot is always kept free for the marker, so a frame's marker is
//   only dropped when earlier markers have not been read yet.
//   Optional feature macro: MERGE_SUPPRESS_EN. When defined, a hit close to the last
//   accepted hit of the same frame is discarded as a duplicate.
module face_result_reporter #(
    parameter int COORD_WIDTH = 10,
    parameter int SCALE_WIDTH = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int MERGE_DIST  = 2
) (
    input  logic                                 clk_fpga,
    input  logic                                 reset_fpga,
    input  logic                                 det_valid,
    input  logic [COORD_WIDTH-1:0]               det_x,
    input  logic [COORD_WIDTH-1:0]               det_y,
    input  logic [SCALE_WIDTH-1:0]               det_scale,
    input  logic                                 frame_end,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [SCALE_WIDTH+2*COORD_WIDTH:0]   res_data,
    output logic [7:0]                           res_count,
    output logic                                 overflow,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level
);

    localparam int W  = 1 + SCALE_WIDTH + 2*COORD_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   LVL_ONE   = 1;
    localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_HITS  = (AW+1)'(FIFO_DEPTH - 1);

    // Marker packs eof, overflow and an 8-bit count; it must fit below the eof bit.
    if (2*COORD_WIDTH + SCALE_WIDTH < 9) begin : g_bad_width
        $error("face_result_reporter: 2*COORD_WIDTH+SCALE_WIDTH must be >= 9");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("face_result_reporter: FIFO_DEPTH must be a power of 2 and >= 4");
    end
    if (MERGE_DIST < 0) begin : g_bad_merge
        $error("face_result_reporter: MERGE_DIST must be non-negative");
    end

    logic [W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic [7:0]    count_reg;
    logic          ovf_reg;

    logic          pop;
    logic          merge_hit;
    logic          hit_req;
    logic          hit_push;
    logic          hit_drop;
    logic          mark_fits;
    logic          mark_push;
    logic          push;
    logic [W-1:0]  marker_word;
    logic [W-1:0]  push_data;

`ifdef MERGE_SUPPRESS_EN
    localparam logic [COORD_WIDTH:0] MERGE_LIM = (COORD_WIDTH+1)'(MERGE_DIST);

    logic                   hist_valid_reg;
    logic [COORD_WIDTH-1:0] last_x_reg;
    logic [COORD_WIDTH-1:0] last_y_reg;
    logic [COORD_WIDTH:0]   dx;
    logic [COORD_WIDTH:0]   dy;

    // Absolute coordinate distance to the last accepted hit of this frame.
    always_comb begin
        dx = '0;
        dy = '0;
        if (det_x >= last_x_reg) dx = {1'b0, det_x} - {1'b0, last_x_reg};
        else                     dx = {1'b0, last_x_reg} - {1'b0, det_x};
        if (det_y >= last_y_reg) dy = {1'b0, det_y} - {1'b0, last_y_reg};
        else                     dy = {1'b0, last_y_reg} - {1'b0, det_y};
    end

    assign merge_hit = hist_valid_reg && det_valid && (dx <= MERGE_LIM) && (dy <= MERGE_LIM);

    // Merge history: remembers the last hit written this frame, forgotten at frame end.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            hist_valid_reg <= 1'b0;
            last_x_reg     <= '0;
            last_y_reg     <= '0;
        end else if (frame_end) begin
            hist_valid_reg <= 1'b0;
        end else if (hit_push) begin
            hist_valid_reg <= 1'b1;
            last_x_reg     <= det_x;
            last_y_reg     <= det_y;
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    // Push/pop decisions; all of them look at the level before this cycle's pop.
    always_comb begin
        pop       = (level_reg != '0) && res_ready;
        hit_req   = det_valid && !frame_end && !merge_hit;
        hit_push  = hit_req && (level_reg < LVL_HITS);
        hit_drop  = hit_req && !(level_reg < LVL_HITS);
        mark_fits = (level_reg < LVL_FULL);
        mark_push = frame_end && mark_fits;
        push      = hit_push || mark_push;
    end

    // Marker word; a hit coinciding with frame_end is lost, so it reports overflow.
    always_comb begin
        marker_word        = '0;
        marker_word[W-1]   = 1'b1;
        marker_word[W-2]   = ovf_reg || det_valid;
        marker_word[7:0]   = count_reg;
    end

    assign push_data = frame_end ? marker_word : {1'b0, det_scale, det_y, det_x};

    // FIFO storage write port (no reset needed: pointers define what is valid).
    always_ff @(posedge clk_fpga) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_ONE;
                2'b01:   level_reg <= level_reg - LVL_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Per-frame hit count and sticky overflow flag.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (frame_end) begin
            count_reg <= '0;
            ovf_reg   <= !mark_fits;
        end else begin
            if (hit_drop) ovf_reg <= 1'b1;
            if (hit_push && count_reg != 8'hFF) count_reg <= count_reg + 8'd1;
        end
    end

    // Outputs: head word is forced to zero when empty so reset clears it at once.
    always_comb begin
        res_valid  = (level_reg != '0);
        res_data   = res_valid ? fifo_mem[rd_ptr_reg] : '0;
        res_count  = count_reg;
        overflow   = ovf_reg;
        fifo_level = level_reg;
    end

endmodule

// File: tb/tb_face_result_reporter.sv
// Directed bench for face_result_reporter: reset, table of per-cycle vectors,
// FIFO fill/overflow, reserved marker slot and a toggling-ready stream.
module tb_face_result_reporter;

`ifdef MERGE_SUPPRESS_EN
    localparam bit MG = 1'b1;
`else
    localparam bit MG = 1'b0;
`endif

    logic        clk_fpga = 1'b0;
    logic        reset_fpga;
    logic        det_valid;
    logic [9:0]  det_x;
    logic [9:0]  det_y;
    logic [3:0]  det_scale;
    logic        frame_end;
    logic        res_valid;
    logic        res_ready;
    logic [24:0] res_data;
    logic [7:0]  res_count;
    logic        overflow;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    face_result_reporter dut (
        .clk_fpga   (clk_fpga),
        .reset_fpga (reset_fpga),
        .det_valid  (det_valid),
        .det_x      (det_x),
        .det_y      (det_y),
        .det_scale  (det_scale),
        .frame_end  (frame_end),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_count  (res_count),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk_fpga = ~clk_fpga;

    typedef struct {
        logic        dv;
        logic        fe;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [3:0]  s;
        logic        ev;
        logic [24:0] ed;
        logic [7:0]  ec;
        logic        eo;
        logic [4:0]  el;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [24:0] hw(input logic [9:0] x, input logic [9:0] y, input logic [3:0] s);
        return {1'b0, s, y, x};
    endfunction

    function automatic logic [24:0] mk(input logic ovf, input logic [7:0] cnt);
        logic [24:0] r;
        r = '0;
        r[24] = 1'b1;
        r[23] = ovf;
        r[7:0] = cnt;
        return r;
    endfunction

    function automatic vec_t mv(input logic dv, input logic fe, input logic [9:0] x, input logic [9:0] y,
                                input logic [3:0] s, input logic ev, input logic [24:0] ed,
                                input logic [7:0] ec, input logic eo, input logic [4:0] el);
        vec_t v;
        v.dv = dv; v.fe = fe; v.x = x; v.y = y; v.s = s;
        v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo; v.el = el;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic hit(input logic [9:0] x, input logic [9:0] y, input logic [3:0] s);
        det_valid = 1'b1; det_x = x; det_y = y; det_scale = s;
        tick();
        det_valid = 1'b0;
    endtask

    initial begin
        logic [24:0] held;
        logic        stalled;
        int          rx;
        logic [9:0]  cv;

        reset_fpga = 1'b0;
        det_valid = 1'b0; det_x = '0; det_y = '0; det_scale = '0;
        frame_end = 1'b0; res_ready = 1'b1;

        // Vectors: hits, frame_end, same-cycle hit+frame_end, merge candidates.
        tbl[0]  = mv(1,0,10,20,1,   1, hw(10,20,1), 1, 0, 1);
        tbl[1]  = mv(1,0,30,40,2,   1, hw(30,40,2), 2, 0, 1);
        tbl[2]  = mv(1,0,50,60,3,   1, hw(50,60,3), 3, 0, 1);
        tbl[3]  = mv(0,1,0,0,0,     1, mk(0,3),     0, 0, 1);
        tbl[4]  = mv(0,0,0,0,0,     0, '0,          0, 0, 0);
        tbl[5]  = mv(1,0,1,2,0,     1, hw(1,2,0),   1, 0, 1);
        tbl[6]  = mv(1,0,3,4,5,     1, hw(3,4,5),   2, 0, 1);
        tbl[7]  = mv(1,1,7,8,9,     1, mk(1,2),     0, 0, 1);
        tbl[8]  = mv(0,0,0,0,0,     0, '0,          0, 0, 0);
        tbl[9]  = mv(1,0,100,100,1, 1, hw(100,100,1), 1, 0, 1);
        tbl[10] = mv(1,0,101,102,1, !MG, hw(101,102,1), MG ? 8'd1 : 8'd2, 0, MG ? 5'd0 : 5'd1);
        tbl[11] = mv(1,0,104,100,1, 1, hw(104,100,1), MG ? 8'd2 : 8'd3, 0, 1);
        tbl[12] = mv(0,1,0,0,0,     1, mk(0, MG ? 8'd2 : 8'd3), 0, 0, 1);
        tbl[13] = mv(1,0,104,100,2, 1, hw(104,100,2), 1, 0, 1);
        tbl[14] = mv(1,0,102,102,2, !MG, hw(102,102,2), MG ? 8'd1 : 8'd2, 0, MG ? 5'd0 : 5'd1);
        tbl[15] = mv(1,0,107,100,2, 1, hw(107,100,2), MG ? 8'd2 : 8'd3, 0, 1);
        tbl[16] = mv(0,1,0,0,0,     1, mk(0, MG ? 8'd2 : 8'd3), 0, 0, 1);
        tbl[17] = mv(0,0,0,0,0,     0, '0,          0, 0, 0);

        // Reset state while reset is held.
        #12;
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_count", 32'(res_count), 0);
        chk("rst_ovf",   32'(overflow), 0);
        chk("rst_data",  32'(res_data), 0);
        reset_fpga = 1'b1;
        tick();

        // Async reset mid-stream with 5 words queued.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) hit(10'(i + 1), 10'(i), 4'(i));
        chk("pre_rst_level", 32'(fifo_level), 5);
        chk("pre_rst_count", 32'(res_count), 5);
        #3;
        reset_fpga = 1'b0;
        #1;
        $display("async reset asserted with 5 words queued");
        chk("mid_rst_valid", 32'(res_valid), 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_count", 32'(res_count), 0);
        chk("mid_rst_ovf",   32'(overflow), 0);
        chk("mid_rst_data",  32'(res_data), 0);
        #2;
        reset_fpga = 1'b1;
        res_ready = 1'b1;
        tick();

        // Table-driven vectors, ready held high.
        for (int i = 0; i < 18; i++) begin
            det_valid = tbl[i].dv; frame_end = tbl[i].fe;
            det_x = tbl[i].x; det_y = tbl[i].y; det_scale = tbl[i].s;
            tick();
            $display("vec %0d: dv=%0d fe=%0d x=%0d y=%0d -> valid=%0d data=%h count=%0d ovf=%0d level=%0d",
                     i, tbl[i].dv, tbl[i].fe, tbl[i].x, tbl[i].y, res_valid, res_data, res_count, overflow, fifo_level);
            chk($sformatf("vec%0d_valid", i), 32'(res_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(tbl[i].el));
            chk($sformatf("vec%0d_count", i), 32'(res_count), 32'(tbl[i].ec));
            chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(tbl[i].eo));
            if (tbl[i].ev) chk($sformatf("vec%0d_data", i), 32'(res_data), 32'(tbl[i].ed));
        end
        det_valid = 1'b0; frame_end = 1'b0;

        // Overflow: 20 hits with reader stalled, marker fills the reserved slot.
        res_ready = 1'b0;
        for (int i = 0; i < 20; i++) hit(10'(200 + i), 10'(i), 4'(i));
        $display("ovf: 20 hits stalled -> level=%0d count=%0d ovf=%0d", fifo_level, res_count, overflow);
        chk("ovf_level15", 32'(fifo_level), 15);
        chk("ovf_count15", 32'(res_count), 15);
        chk("ovf_flag",    32'(overflow), 1);
        chk("ovf_head",    32'(res_data), 32'(hw(200, 0, 0)));
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        chk("ovf_level16", 32'(fifo_level), 16);
        chk("ovf_cnt_clr", 32'(res_count), 0);
        chk("ovf_flag_clr", 32'(overflow), 0);
        chk("ovf_head_hold", 32'(res_data), 32'(hw(200, 0, 0)));
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        $display("ovf: marker into full fifo -> level=%0d ovf=%0d", fifo_level, overflow);
        chk("drop_mark_level", 32'(fifo_level), 16);
        chk("drop_mark_ovf",   32'(overflow), 1);
        chk("drop_mark_cnt",   32'(res_count), 0);
        hit(10'd5, 10'd5, 4'd5);
        chk("full_hit_level", 32'(fifo_level), 16);
        chk("full_hit_cnt",   32'(res_count), 0);
        res_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d_valid", k), 32'(res_valid), 1);
            if (k < 15) chk($sformatf("drain%0d_data", k), 32'(res_data), 32'(hw(10'(200 + k), 10'(k), 4'(k))));
            else        chk("drain_marker", 32'(res_data), 32'(mk(1, 8'd15)));
            tick();
        end
        chk("drained_level", 32'(fifo_level), 0);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        chk("ovf_frame_marker", 32'(res_data), 32'(mk(1, 8'd0)));
        chk("ovf_frame_clear",  32'(overflow), 0);
        tick();
        chk("empty_again", 32'(fifo_level), 0);

        // Reserved slot: hit at level 15 is dropped even with a pop in the same cycle.
        res_ready = 1'b0;
        for (int i = 0; i < 15; i++) hit(10'(300 + i), 10'(i), 4'(i));
        res_ready = 1'b1;
        hit(10'd999, 10'd999, 4'd9);
        $display("reserve: hit+pop at level 15 -> level=%0d ovf=%0d", fifo_level, overflow);
        chk("rsv_level", 32'(fifo_level), 14);
        chk("rsv_ovf",   32'(overflow), 1);
        chk("rsv_count", 32'(res_count), 15);
        chk("rsv_head",  32'(res_data), 32'(hw(301, 1, 1)));
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        chk("rsv_fe_level", 32'(fifo_level), 14);
        for (int t = 0; t < 20 && fifo_level != 0; t++) begin
            if (fifo_level == 1) chk("rsv_marker", 32'(res_data), 32'(mk(1, 8'd15)));
            tick();
        end
        chk("rsv_drained", 32'(fifo_level), 0);

        // Toggling ready over 10 words: no loss, no duplicates, data stable while stalled.
        rx = 0;
        for (int cyc = 0; cyc < 60 && rx < 10; cyc++) begin
            cv = 10'(cyc);
            det_valid = (cyc < 10);
            det_x = 10'd400 + cv; det_y = cv; det_scale = cv[3:0];
            res_ready = cv[0];
            stalled = 1'b0;
            held = res_data;
            if (res_valid && res_ready) begin
                cv = 10'(rx);
                $display("stream word %0d: data=%h", rx, res_data);
                chk($sformatf("stream%0d_data", rx), 32'(res_data), 32'(hw(10'd400 + cv, cv, cv[3:0])));
                rx++;
            end else if (res_valid) begin
                stalled = 1'b1;
            end
            tick();
            if (stalled) chk("stall_hold", 32'(res_data), 32'(held));
        end
        det_valid = 1'b0;
        chk("stream_received", 32'(rx), 10);
        chk("stream_level",    32'(fifo_level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
